// File: rtl/des_pkg.sv
// DES key-schedule tables, types and helpers shared by des_key_schedule and des_pc2.
// Optional DES_DECRYPT_EN adds the right-rotate helper used by reverse-order schedules.
package des_pkg;

   localparam int unsigned KEY_W    = 64;
   localparam int unsigned HALF_W   = 28;
   localparam int unsigned SUBKEY_W = 48;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      DONE = 2'd2
   } des_ks_state_t;

   // Entries are DES bit numbers (1 = MSB of the source vector)
   localparam int unsigned PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   function automatic logic [2*HALF_W-1:0] pc1_perm(input logic [KEY_W-1:0] key);
      pc1_perm = '0;
      for (int unsigned i = 0; i < 56; i++) begin
         pc1_perm[55 - i] = key[64 - PC1[i]];
      end
   endfunction

   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input int unsigned s);
      rotl28 = (s == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

`ifdef DES_DECRYPT_EN
   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input int unsigned s);
      rotr28 = (s == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction
`endif

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: combinational 56-bit {C,D} to 48-bit subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [2*HALF_W-1:0] cd_i,
   output logic [SUBKEY_W-1:0] subkey_o
);

   always_comb begin
      subkey_o = '0;
      for (int unsigned i = 0; i < SUBKEY_W; i++) begin
         subkey_o[47 - i] = cd_i[56 - PC2[i]];
      end
   end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one 48-bit subkey per valid/ready handshake.
// Define DES_DECRYPT_EN to add the decrypt port and K16..K1 ordering.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_W-1:0]    key_in,
`ifdef DES_DECRYPT_EN
   input  logic                decrypt,
`endif
   output logic [SUBKEY_W-1:0] subkey_out,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [3:0]          round_idx,
   output logic                busy,
   output logic                done
);

   des_ks_state_t     state_q, state_d;
   logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
   logic [HALF_W-1:0] c_rot, d_rot;
   logic [3:0]        round_q, round_d;
   logic [SUBKEY_W-1:0] pc2_out;
`ifdef DES_DECRYPT_EN
   logic              dec_q, dec_d;
   logic [3:0]        ridx;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
`ifdef DES_DECRYPT_EN
         dec_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
`ifdef DES_DECRYPT_EN
         dec_q   <= dec_d;
`endif
      end
   end

   // C/D hold the pre-rotation halves of the current round; the rotation is applied
   // combinationally for the subkey and committed on the handshake.
   always_comb begin
      c_rot = rotl28(c_q, SHIFT[round_q]);
      d_rot = rotl28(d_q, SHIFT[round_q]);
`ifdef DES_DECRYPT_EN
      ridx = 4'd0 - round_q;
      if (dec_q) begin
         if (round_q == '0) begin
            c_rot = c_q;
            d_rot = d_q;
         end else begin
            c_rot = rotr28(c_q, SHIFT[ridx]);
            d_rot = rotr28(d_q, SHIFT[ridx]);
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
`ifdef DES_DECRYPT_EN
      dec_d   = dec_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = GEN;
               {c_d, d_d} = pc1_perm(key_in);
               round_d    = '0;
`ifdef DES_DECRYPT_EN
               dec_d      = decrypt;
`endif
            end
         end
         GEN: begin
            if (subkey_ready) begin
               c_d = c_rot;
               d_d = d_rot;
               if (round_q == 4'(NUM_ROUNDS - 1)) begin
                  state_d = DONE;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   des_pc2 u_pc2 (
      .cd_i     ({c_rot, d_rot}),
      .subkey_o (pc2_out)
   );

   assign subkey_valid = (state_q == GEN);
   assign busy         = (state_q == GEN);
   assign done         = (state_q == DONE);
   assign round_idx    = round_q;
   assign subkey_out   = subkey_valid ? pc2_out : '0;

endmodule
